load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter: MAX_WAIT, default 255, meaning the number of cycles spent in ISSUE plus WAIT before the access is aborted with a fault.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  block accepts an access
- req_store  in  1  1 = store, 0 = load
- funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- base  in  32  rs1 value
- offset  in  32  sign-extended immediate
- store_data  in  32  rs2 value
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned byte address
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_gnt  in  1  memory accepts the request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- rsp_valid  out  1  response available
- rsp_ready  in  1  pipeline consumes the response
- rsp_data  out  32  extracted load result; 0 for stores
- rsp_misaligned  out  1  misaligned access; no memory traffic was issued
- rsp_fault  out  1  illegal funct3 or timeout

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; an access is accepted when req_valid=1 and req_ready=1, and all inputs are captured at that edge.
REQ-005 The effective address SHALL be base+offset modulo 2^32, computed at acceptance.
REQ-006 An access SHALL be misaligned when the h/hu/sh address has bit 0 set, or the w/sw address has bits [1:0] not equal to 00.
REQ-007 An access SHALL be illegal when its funct3 is outside the table, or it is a store with funct3 of 100 or 101.
REQ-008 On acceptance, a misaligned or illegal access SHALL go IDLE->RESP, never assert mem_req, and set rsp_misaligned or rsp_fault respectively; misaligned takes precedence over illegal.
REQ-009 Otherwise the FSM SHALL go IDLE->ISSUE.
REQ-010 In ISSUE, mem_req SHALL be 1, and mem_we, mem_addr, mem_wstrb and mem_wdata SHALL be held stable until the cycle mem_gnt=1.
REQ-011 mem_addr SHALL be {ea[31:2],2'b00}.
REQ-012 Store byte enables and data SHALL be:
- sb: mem_wstrb = 0001 shifted left by ea[1:0]; mem_wdata = byte replicated 4x
- sh: mem_wstrb = 0011 (ea[1]=0) or 1100 (ea[1]=1); mem_wdata = half replicated 2x
- sw: mem_wstrb = 1111
REQ-013 For loads, mem_we SHALL be 0 and mem_wstrb SHALL be 0000.
REQ-014 When mem_gnt=1 in ISSUE, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-015 mem_rvalid SHALL be honoured only in WAIT; mem_rvalid in any other state, including the grant cycle, SHALL be ignored.
REQ-016 When mem_rvalid=1 in WAIT, the FSM SHALL go to RESP and register rsp_data from mem_rdata:
- lb/lh: byte/half selected by ea[1:0]/ea[1], sign-extended
- lbu/lhu: same selection, zero-extended
- lw: full word
REQ-017 A cycle counter SHALL clear on acceptance and increment in ISSUE and WAIT; when it reaches MAX_WAIT, the FSM SHALL go to RESP with rsp_fault=1 and rsp_data=0, and mem_req SHALL drop that cycle.
REQ-018 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_misaligned/rsp_fault SHALL be stable until rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-019 A new request SHALL NOT be accepted in the cycle the FSM leaves RESP.
REQ-020 Minimum latency from acceptance edge to rsp_valid SHALL be: store with immediate grant, 2 cycles; load with grant and then rvalid on the next cycle, 3 cycles; misaligned or illegal, 1 cycle.
REQ-021 Outputs rsp_valid, rsp_data, rsp_misaligned and rsp_fault SHALL be registered.

Reset
REQ-022 While rst_n=0, regardless of the clock, the block SHALL be in IDLE, the counter SHALL be 0, req_ready SHALL be 1, and every other output SHALL be 0.
REQ-023 Reset asserted mid-access SHALL abandon the access without a response; a mem_rvalid arriving after reset SHALL be ignored.

Verification
REQ-024 sb: base=0x100, offset=3, store_data=0x000000A5, immediate grant -> mem_addr=0x100, mem_wstrb=1000, mem_wdata=0xA5A5A5A5; rsp_valid 2 cycles after acceptance; rsp_data=0.
REQ-025 lh: ea=0x202, mem_rdata=0x8001_1234 one cycle after grant -> rsp_data=0xFFFF8001; lhu of the same word -> rsp_data=0x00008001.
REQ-026 lw: ea=0x301 -> rsp_misaligned=1 one cycle after acceptance, mem_req never asserted; funct3=011 -> rsp_fault=1.
REQ-027 mem_gnt held low for 3 cycles -> address and strobes stable throughout; a spurious mem_rvalid in the grant cycle is ignored; the later mem_rvalid returns correct lbu data.
REQ-028 MAX_WAIT=4 with mem_rvalid never asserted -> rsp_fault=1 after 4 cycles in ISSUE+WAIT; a late mem_rvalid is ignored; rsp_valid is held until rsp_ready=1; rst_n pulsed low in WAIT -> all outputs 0 immediately and req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline access into a single-beat memory transaction
// and returns the aligned, extended result (or a misaligned / fault status).
module load_store_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_misaligned,
    output logic        rsp_fault
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cap_store;
    logic [2:0]    cap_f3;
    logic [1:0]    cap_lo;

    logic [31:0] ea;
    logic        misaligned;
    logic        illegal;
    logic [3:0]  wstrb_next;
    logic [31:0] wdata_next;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_result;

    assign ea = base + offset;

    // Alignment is judged by access size alone, so a misaligned access wins over an illegal one.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = ea[0];
            3'b010:         misaligned = (ea[1:0] != 2'b00);
            default:        illegal    = 1'b1;
        endcase
        if (req_store && funct3[2])
            illegal = 1'b1;
    end

    always_comb begin
        wstrb_next = 4'b1111;
        wdata_next = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb_next = 4'b0001 << ea[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_next = ea[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_next = 4'b1111;
                wdata_next = store_data;
            end
        endcase
    end

    assign rd_byte = mem_rdata[{cap_lo, 3'b000} +: 8];
    assign rd_half = cap_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (cap_f3)
            3'b000:  load_result = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_result = {24'd0, rd_byte};
            3'b001:  load_result = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_result = {16'd0, rd_half};
            default: load_result = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_store      <= 1'b0;
            cap_f3         <= 3'b000;
            cap_lo         <= 2'b00;
            req_ready      <= 1'b1;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'd0;
            mem_wstrb      <= 4'd0;
            mem_wdata      <= 32'd0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'd0;
            rsp_misaligned <= 1'b0;
            rsp_fault      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        cap_store <= req_store;
                        cap_f3    <= funct3;
                        cap_lo    <= ea[1:0];
                        rsp_data  <= 32'd0;
                        if (misaligned || illegal) begin
                            state          <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_misaligned <= misaligned;
                            rsp_fault      <= !misaligned;
                        end else begin
                            state     <= ISSUE;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {ea[31:2], 2'b00};
                            mem_wstrb <= req_store ? wstrb_next : 4'd0;
                            mem_wdata <= req_store ? wdata_next : 32'd0;
                        end
                    end
                end
                // A granted store completes; a load granted on the final budget cycle still times out.
                ISSUE: begin
                    if (mem_gnt && cap_store) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'd0;
                        rsp_valid <= 1'b1;
                    end else if (cnt == LAST) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (mem_gnt) begin
                            state   <= WAIT;
                            mem_req <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= load_result;
                    end else if (cnt == LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state          <= IDLE;
                        req_ready      <= 1'b1;
                        rsp_valid      <= 1'b0;
                        rsp_data       <= 32'd0;
                        rsp_misaligned <= 1'b0;
                        rsp_fault      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; a second instance with a 4-cycle budget covers the timeout path.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_store, mem_gnt, mem_rvalid, rsp_ready;
    logic [2:0]  funct3;
    logic [31:0] base, offset, store_data, mem_rdata;

    logic        req_ready, mem_req, mem_we, rsp_valid, rsp_misaligned, rsp_fault;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [3:0]  mem_wstrb;

    logic        s_req_ready, s_mem_req, s_mem_we, s_rsp_valid, s_rsp_misaligned, s_rsp_fault;
    logic [31:0] s_mem_addr, s_mem_wdata, s_rsp_data;
    logic [3:0]  s_mem_wstrb;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .funct3(funct3), .base(base), .offset(offset),
        .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned),
        .rsp_fault(rsp_fault)
    );

    load_store_unit #(.MAX_WAIT(4)) dut_short (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_store(req_store), .funct3(funct3), .base(base), .offset(offset),
        .store_data(store_data), .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wstrb(s_mem_wstrb), .mem_wdata(s_mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(s_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_misaligned(s_rsp_misaligned),
        .rsp_fault(s_rsp_fault)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one access for exactly one edge, then scramble the inputs to prove they were captured.
    task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] b,
                                 input logic [31:0] o, input logic [31:0] sd);
        checkOutput("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_store  = store;
        funct3     = f3;
        base       = b;
        offset     = o;
        store_data = sd;
        req_valid  = 1'b1;
        tick;
        req_valid  = 1'b0;
        req_store  = ~store;
        funct3     = 3'b111;
        base       = 32'h0BAD_0BAD;
        offset     = 32'h0000_0001;
        store_data = 32'h5555_5555;
    endtask

    task automatic finishRsp(input string tag);
        checkOutput({tag, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        checkOutput({tag, "_rsp_cleared"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic pulseReset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; funct3 = 3'b000;
        base = 32'd0; offset = 32'd0; store_data = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; rsp_ready = 1'b0;

        // Reset state, observed with the clock running but reset held.
        #12;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_flags", {27'd0, mem_req, mem_we, rsp_valid, rsp_misaligned, rsp_fault}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // sb to 0x103 with immediate grant
        applyStimulus(1'b1, 3'b000, 32'h100, 32'd3, 32'h0000_00A5);
        checkOutput("sb_mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("sb_mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("sb_addr", mem_addr, 32'h100);
        checkOutput("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
        checkOutput("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        checkOutput("sb_rsp_valid_lat2", {31'd0, rsp_valid}, 32'd1);
        checkOutput("sb_rsp_data", rsp_data, 32'd0);
        checkOutput("sb_status", {30'd0, rsp_misaligned, rsp_fault}, 32'd0);
        checkOutput("sb_mem_req_drop", {31'd0, mem_req}, 32'd0);
        finishRsp("sb");

        // sh to 0x402 (upper half) and sw to 0x404
        applyStimulus(1'b1, 3'b001, 32'h400, 32'd2, 32'h1234_BEEF);
        checkOutput("sh_addr", mem_addr, 32'h400);
        checkOutput("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        checkOutput("sh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        finishRsp("sh");

        applyStimulus(1'b1, 3'b010, 32'h404, 32'd0, 32'hCAFE_F00D);
        checkOutput("sw_addr", mem_addr, 32'h404);
        checkOutput("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
        checkOutput("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        checkOutput("sw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        finishRsp("sw");

        // lh from 0x202, rvalid one cycle after grant
        applyStimulus(1'b0, 3'b001, 32'h200, 32'd2, 32'hFFFF_FFFF);
        checkOutput("lh_mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("lh_addr", mem_addr, 32'h200);
        checkOutput("lh_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        checkOutput("lh_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        checkOutput("lh_mem_req_drop", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234; tick; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        checkOutput("lh_rsp_valid_lat3", {31'd0, rsp_valid}, 32'd1);
        checkOutput("lh_data", rsp_data, 32'hFFFF_8001);
        finishRsp("lh");

        // lhu of the same word, ea reached through a negative offset
        applyStimulus(1'b0, 3'b101, 32'h210, 32'hFFFF_FFF2, 32'd0);
        checkOutput("lhu_addr", mem_addr, 32'h200);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234; tick; mem_rvalid = 1'b0;
        checkOutput("lhu_data", rsp_data, 32'h0000_8001);
        finishRsp("lhu");

        // lb from 0x701 picks byte 1 and sign-extends
        applyStimulus(1'b0, 3'b000, 32'h700, 32'd1, 32'd0);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_F080; tick; mem_rvalid = 1'b0;
        checkOutput("lb_data", rsp_data, 32'hFFFF_FFF0);
        finishRsp("lb");

        // lw from 0x301 is misaligned; a waiting request is not taken as RESP exits
        applyStimulus(1'b0, 3'b010, 32'h300, 32'd1, 32'd0);
        checkOutput("lw_mis_rsp_lat1", {31'd0, rsp_valid}, 32'd1);
        checkOutput("lw_mis_status", {30'd0, rsp_misaligned, rsp_fault}, 32'h2);
        checkOutput("lw_mis_no_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("lw_mis_data", rsp_data, 32'd0);
        req_store = 1'b0; funct3 = 3'b011; base = 32'h0; offset = 32'h0; req_valid = 1'b1;
        finishRsp("lw_mis");
        checkOutput("no_accept_on_resp_exit", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b0;

        // illegal funct3 011, store with funct3 100, misaligned sh
        applyStimulus(1'b0, 3'b011, 32'h300, 32'd0, 32'd0);
        checkOutput("f3_011_status", {30'd0, rsp_misaligned, rsp_fault}, 32'h1);
        checkOutput("f3_011_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("f3_011_no_mem_req", {31'd0, mem_req}, 32'd0);
        finishRsp("f3_011");

        applyStimulus(1'b1, 3'b100, 32'h300, 32'd0, 32'd0);
        checkOutput("sbu_status", {30'd0, rsp_misaligned, rsp_fault}, 32'h1);
        finishRsp("sbu");

        applyStimulus(1'b1, 3'b001, 32'h100, 32'd1, 32'd0);
        checkOutput("sh_mis_status", {30'd0, rsp_misaligned, rsp_fault}, 32'h2);
        checkOutput("sh_mis_no_mem_req", {31'd0, mem_req}, 32'd0);
        finishRsp("sh_mis");

        // lbu from 0x503: grant held off 3 cycles, spurious rvalid in the grant cycle
        applyStimulus(1'b0, 3'b100, 32'h500, 32'd3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_mem_req", {31'd0, mem_req}, 32'd1);
            checkOutput("stall_addr", mem_addr, 32'h500);
            checkOutput("stall_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
            tick;
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        checkOutput("spurious_rvalid_ignored", {31'd0, rsp_valid}, 32'd0);
        checkOutput("stall_mem_req_drop", {31'd0, mem_req}, 32'd0);
        tick;
        checkOutput("wait_still_no_rsp", {31'd0, rsp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hC311_2233; tick; mem_rvalid = 1'b0;
        checkOutput("lbu_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("lbu_data", rsp_data, 32'h0000_00C3);
        finishRsp("lbu");

        // Timeout on the 4-cycle instance: no grant ever arrives
        pulseReset;
        applyStimulus(1'b0, 3'b010, 32'h600, 32'd0, 32'd0);
        checkOutput("to_mem_req", {31'd0, s_mem_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("to_pending", {30'd0, s_rsp_valid, s_mem_req}, 32'h1);
        end
        tick;
        checkOutput("to_rsp_valid", {31'd0, s_rsp_valid}, 32'd1);
        checkOutput("to_status", {30'd0, s_rsp_misaligned, s_rsp_fault}, 32'h1);
        checkOutput("to_mem_req_drop", {31'd0, s_mem_req}, 32'd0);
        checkOutput("to_data", s_rsp_data, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; tick; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        checkOutput("to_late_rvalid_data", s_rsp_data, 32'd0);
        checkOutput("to_late_rvalid_fault", {31'd0, s_rsp_fault}, 32'd1);
        tick; tick;
        checkOutput("to_held", {31'd0, s_rsp_valid}, 32'd1);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        checkOutput("to_released", {31'd0, s_rsp_valid}, 32'd0);
        checkOutput("to_ready_back", {31'd0, s_req_ready}, 32'd1);

        // Reset in WAIT abandons the load; the later rvalid is ignored
        pulseReset;
        applyStimulus(1'b0, 3'b010, 32'h700, 32'd0, 32'd0);
        mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
        checkOutput("pre_rst_in_wait", {29'd0, req_ready, mem_req, rsp_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("async_rst_flags", {27'd0, mem_req, mem_we, rsp_valid, rsp_misaligned, rsp_fault}, 32'd0);
        checkOutput("async_rst_addr", mem_addr, 32'd0);
        checkOutput("async_rst_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick;
        mem_rvalid = 1'b0;
        checkOutput("post_rst_rvalid_ignored", {31'd0, rsp_valid}, 32'd0);
        checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
        tick;
        checkOutput("post_rst_idle", {30'd0, rsp_valid, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
